// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8-way 32-bit operand mux.
// Optional grant counter port enabled by defining ARB_GRANT_CNT_EN.
module mux8_rr_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [7:0]        grant,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]       grant_cnt
`endif
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned GCNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t              state, nxt_state;
  logic [SEL_W-1:0]    ptr, nxt_ptr;
  logic [SEL_W-1:0]    nxt_sel;
  logic [N_REQ-1:0]    nxt_grant;
  logic [DATA_W-1:0]   nxt_out;
  logic                nxt_out_valid;
  logic [CNT_W-1:0]    beat_cnt, nxt_beat_cnt;
  logic                release_c;
  logic [SEL_W-1:0]    rel_ptr_c;
  logic [SEL_W-1:0]    idle_win_c;
  logic [SEL_W-1:0]    rel_win_c;
  logic [DATA_W-1:0]   mux_word;

  // First requester at or after p, wrapping modulo 8.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] p);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + SEL_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  Mux8to1 u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .in5 (in5),
    .in6 (in6),
    .in7 (in7),
    .sel (sel),
    .out (mux_word)
  );

  assign rel_ptr_c  = sel + SEL_W'(1);
  assign idle_win_c = rr_pick(req, ptr);
  assign rel_win_c  = rr_pick(req, rel_ptr_c);
  assign busy       = (state == ST_GRANT);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      sel       <= nxt_sel;
      grant     <= nxt_grant;
      out       <= nxt_out;
      out_valid <= nxt_out_valid;
      beat_cnt  <= nxt_beat_cnt;
    end
  end

  // Next-state: arbitration, beat capture and zero-bubble re-arbitration.
  always_comb begin
    nxt_state     = state;
    nxt_ptr       = ptr;
    nxt_sel       = sel;
    nxt_grant     = grant;
    nxt_out       = out;
    nxt_out_valid = 1'b0;
    nxt_beat_cnt  = beat_cnt;
    release_c     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          nxt_sel      = idle_win_c;
          nxt_grant    = N_REQ'(1) << idle_win_c;
          nxt_beat_cnt = '0;
          nxt_state    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req[sel]) begin
          nxt_out       = mux_word;
          nxt_out_valid = 1'b1;
          nxt_beat_cnt  = beat_cnt + CNT_W'(1);
          release_c     = (beat_cnt == LAST_BEAT);
        end else begin
          release_c = 1'b1;
        end

        // Releasing grantee drops to lowest priority via ptr = sel + 1.
        if (release_c) begin
          nxt_ptr = rel_ptr_c;
          if (|req) begin
            nxt_sel      = rel_win_c;
            nxt_grant    = N_REQ'(1) << rel_win_c;
            nxt_beat_cnt = '0;
          end else begin
            nxt_grant = '0;
            nxt_state = ST_IDLE;
          end
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_grant = '0;
      end
    endcase
  end

`ifdef ARB_GRANT_CNT_EN
  logic new_grant_c;

  assign new_grant_c = (|req) && ((state == ST_IDLE) || release_c);

  // Counts every issued grant; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (new_grant_c) begin
      grant_cnt <= grant_cnt + GCNT_W'(1);
    end
  end
`endif

endmodule

// Shared 8-way 32-bit operand mux used by the datapath.
module Mux8to1 (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [31:0] in3,
  input  logic [31:0] in4,
  input  logic [31:0] in5,
  input  logic [31:0] in6,
  input  logic [31:0] in7,
  input  logic [2:0]  sel,
  output logic [31:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      3'd0:    out = in0;
      3'd1:    out = in1;
      3'd2:    out = in2;
      3'd3:    out = in3;
      3'd4:    out = in4;
      3'd5:    out = in5;
      3'd6:    out = in6;
      3'd7:    out = in7;
      default: out = in0;
    endcase
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: single requester, all-request rotation,
// early drop, pointer wrap, async reset and (if enabled) the grant counter.
module tb_mux8_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [31:0] in_arr [8];
  logic [7:0]  grant;
  logic [2:0]  sel;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  int n_checks;
  int n_errors;
  int prev_idx;
  int exp_idx;

  mux8_rr_arbiter #(
    .DATA_W    (32),
    .BURST_LEN (4),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in_arr[0]),
    .in1       (in_arr[1]),
    .in2       (in_arr[2]),
    .in3       (in_arr[3]),
    .in4       (in_arr[4]),
    .in5       (in_arr[5]),
    .in6       (in_arr[6]),
    .in7       (in_arr[7]),
    .grant     (grant),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_out", out, 32'h0);
`ifdef ARB_GRANT_CNT_EN
    check("rst_gcnt", 32'(grant_cnt), 32'h0);
`endif
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    for (int i = 0; i < 8; i++) in_arr[i] = 32'hA5A5_0000 | 32'(i);
    in_arr[2] = 32'hDEADBEEF;

    #1;
    check("init_grant", 32'(grant), 32'h0);
    check("init_sel", 32'(sel), 32'h0);
    check("init_out", out, 32'h0);
    check("init_valid", 32'(out_valid), 32'h0);
    check("init_busy", 32'(busy), 32'h0);
    #6;
    rst_n = 1'b1;

    // Idle with no requests stays idle.
    tick();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Single requester 2, held 6 beats across a forced burst boundary.
    req = 8'h04;
    tick();
    check("t1_grant", 32'(grant), 32'h04);
    check("t1_sel", 32'(sel), 32'd2);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_nobeat", 32'(out_valid), 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_out", out, 32'hDEADBEEF);
      check("t1_grant_hold", 32'(grant), 32'h04);
      check("t1_busy_hold", 32'(busy), 32'h1);
    end
    req = 8'h00;
    tick();
    check("t1_rel_grant", 32'(grant), 32'h0);
    check("t1_rel_valid", 32'(out_valid), 32'h0);
    check("t1_rel_busy", 32'(busy), 32'h0);
    check("t1_sel_hold", 32'(sel), 32'd2);
    check("t1_out_hold", out, 32'hDEADBEEF);
`ifdef ARB_GRANT_CNT_EN
    check("t1_gcnt", 32'(grant_cnt), 32'd2);
`endif

    // All request: bursts of 4 rotate 0..7,0,1 with no idle gap.
    pulse_reset();
    req = 8'hFF;
    prev_idx = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        exp_idx = b % 8;
        check("t2_grant", 32'(grant), 32'h1 << exp_idx);
        check("t2_busy", 32'(busy), 32'h1);
        if (b != 0 || k != 0) begin
          check("t2_valid", 32'(out_valid), 32'h1);
          check("t2_out", out, in_arr[prev_idx]);
        end
        prev_idx = exp_idx;
      end
    end
`ifdef ARB_GRANT_CNT_EN
    check("t2_gcnt", 32'(grant_cnt), 32'd10);
`endif
    pulse_reset();

    // Early drop: grantee 5 leaves after 2 beats, 6 takes over.
    req = 8'h60;
    tick();
    check("t3_grant5", 32'(grant), 32'h20);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t3_valid", 32'(out_valid), 32'h1);
      check("t3_out5", out, in_arr[5]);
    end
    req = 8'h40;
    tick();
    check("t3_grant6", 32'(grant), 32'h40);
    check("t3_drop_valid", 32'(out_valid), 32'h0);
    check("t3_out_hold", out, in_arr[5]);
    tick();
    check("t3_out6", out, in_arr[6]);
    check("t3_valid6", 32'(out_valid), 32'h1);

    // Wrap: ptr lands on 7 after 6 releases; 7 then 0.
    req = 8'h81;
    tick();
    check("t4_grant7", 32'(grant), 32'h80);
    check("t4_sel7", 32'(sel), 32'd7);
    check("t4_rel_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_out7", out, in_arr[7]);
      check("t4_grant_seq", 32'(grant), (k == 3) ? 32'h01 : 32'h80);
    end
    tick();
    check("t4_out0", out, in_arr[0]);
    check("t4_valid0", 32'(out_valid), 32'h1);

    // Async reset mid-burst, then a fresh grant from ptr=0.
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_grant", 32'(grant), 32'h0);
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_out", out, 32'h0);
`ifdef ARB_GRANT_CNT_EN
    check("t5_gcnt", 32'(grant_cnt), 32'h0);
`endif
    req = 8'h10;
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_grant4", 32'(grant), 32'h10);
    check("t5_sel4", 32'(sel), 32'd4);
    tick();
    check("t5_out4", out, in_arr[4]);
    check("t5_valid4", 32'(out_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
